keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Sequences the 4x4 keypad datapath: drives column strobes, samples rows on a slow scan tick,
//  debounces press and release, then queues one 6-bit {col,row} key code per keystroke.
//  Codes are buffered in a small FIFO and handed downstream on a valid/ready handshake.
//  Replaces the free-running key read/latch pair as the single keypad front end.
// PARAMETERS
//  SCAN_DIV        50000  clk cycles per scan tick; range 2..65535
//  DEBOUNCE_TICKS  4      consecutive stable ticks required for press and for release; range 1..15
//  FIFO_DEPTH      4      key-code FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk         in   1   system clock; all state changes on posedge
//  rst         in   1   synchronous reset, active-high
//  keyrow      in   4   row sense lines, active-low; 4'b1111 means no key
//  keycolumn   out  4   column strobe, one-low: idx0=0111, idx1=1011, idx2=1101, idx3=1110
//  key_data    out  6   FIFO head code = {col_idx[1:0], row[3:0]}
//  key_valid   out  1   FIFO not empty
//  key_ready   in   1   consumer accepts key_data when key_valid && key_ready (pop)
//  fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
//  overflow    out  1   sticky: a completed keystroke was dropped because the FIFO was full
//  clr_ovf     in   1   clears overflow; a drop in the same cycle wins
// BEHAVIOUR
//  Reset values: keycolumn=0111 (col_idx 0), key_data=0, key_valid=0, fifo_count=0, overflow=0.
//  Internal reset values: state SCAN, divider 0, debounce count 0, candidate 0.
//  Tick: divider counts 0..SCAN_DIV-1; tick is high for one clk while divider==SCAN_DIV-1.
//  keyrow is sampled only on tick cycles. No input synchronizer is included; keyrow is
//  already registered upstream.
//  FSM (transitions occur only on tick cycles):
//   SCAN:   keyrow==1111 -> advance col_idx mod 4 (3->0 wraps), stay in SCAN.
//           Otherwise latch cand={col_idx,keyrow}, set db=1 and go to PRESS_DB.
//   PRESS_DB: keycolumn is frozen. keyrow!=cand.row -> SCAN, col_idx unchanged (bounce rejected).
//           keyrow==cand.row -> db++. When db reaches DEBOUNCE_TICKS -> HELD.
//           With DEBOUNCE_TICKS=1 the FSM goes directly from SCAN to HELD.
//   HELD:   keyrow==1111 -> db=1 and go to REL_DB. Otherwise stay in HELD (no autorepeat).
//   REL_DB: keyrow!=1111 -> HELD. keyrow==1111 -> db++. When db reaches DEBOUNCE_TICKS, push cand,
//           advance col_idx and go to SCAN.
//  Multiple rows low: the raw row pattern goes into cand unchanged, with no priority encoding.
//  Exactly one push per keystroke. The push is asserted for one clk, on the completing tick.
//  FIFO:
//   - key_data/key_valid reflect the head entry. A push into an empty FIFO is visible the next clk.
//   - Push while full with no pop: code dropped, overflow<=1, contents unchanged.
//   - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
//   - Push and pop in the same cycle while empty: impossible, because pop requires valid.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - key_data must hold stable while key_valid && !key_ready.
//  rst mid-keystroke: the pending candidate is discarded, the FIFO is emptied and overflow is cleared.
//  A key still held after reset is detected as a fresh press.
// STRUCTURE
//  keypad_pkg: state enum (SCAN, PRESS_DB, HELD, REL_DB), KEY_CODE_W=6, column strobe LUT function.
//  Sub-module key_fifo (parameterised DEPTH/WIDTH, sync reset, push/pop/full/empty/count).
//  The scanner FSM, tick divider and debounce counter stay in keypad_scan_ctrl.
// TESTING (SCAN_DIV=4, DEBOUNCE_TICKS=3, FIFO_DEPTH=4)
//  1. Idle rows=1111 for 20 ticks -> keycolumn cycles 0111,1011,1101,1110,0111...,
//     one step per 4 clk; key_valid stays 0.
//  2. At col_idx 2, drive row=1011 for 5 ticks, then 1111 for 3 ticks -> exactly one push;
//     key_data=6'b10_1011, key_valid=1 one clk after the completing tick.
//  3. At col_idx 1, glitch row=1110 for 1 tick, then 1111 -> no push; col_idx stays 1 and
//     resumes scanning on the next tick.
//  4. Release bounce: 1111,1101,1111,1111,1111 during REL_DB -> returns to HELD,
//     then a single push after 3 clean ticks.
//  5. key_ready=0, 5 keystrokes -> fifo_count=4, overflow=1, head equals the first code.
//     Pulse clr_ovf -> overflow=0. Drain 4 pops -> codes come out in order, then key_valid=0.
//  6. Assert rst during HELD -> all outputs at reset values next clk.
//     Key still held after rst deasserts -> detected and pushed once after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, key code width
// and the column strobe lookup.
package keypad_pkg;

    localparam int KEY_CODE_W = 6;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } scan_state_e;

    // One-low column strobe; column 0 drives the MSB low.
    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] strobe;
        unique case (idx)
            2'd0:    strobe = 4'b0111;
            2'd1:    strobe = 4'b1011;
            2'd2:    strobe = 4'b1101;
            default: strobe = 4'b1110;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key codes. Storage is not reset; the head output
// reads zero while empty so the visible data still starts at zero.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = KEY_CODE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad front end: scan tick divider, column scanning FSM with press and
// release debounce, and a key-code FIFO with valid/ready output.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    keyrow,
    output logic [3:0]                    keycolumn,
    output logic [KEY_CODE_W-1:0]         key_data,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_TICKS);
    localparam logic        DB_ONE   = (DEBOUNCE_TICKS == 1);

    logic [15:0]           div;
    logic                  tick;
    scan_state_e           state;
    logic [1:0]            col_idx;
    logic [KEY_CODE_W-1:0] cand;
    logic [3:0]            db;
    logic [3:0]            db_next;
    logic                  row_idle;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign tick     = (div == DIV_LAST);
    assign db_next  = db + 4'd1;
    assign row_idle = (keyrow == 4'b1111);

    always_ff @(posedge clk) begin
        if (rst || tick) div <= '0;
        else             div <= div + 16'd1;
    end

    // Push fires on the tick that completes release debounce (or the first
    // release tick when a single stable tick is enough).
    assign push = tick && row_idle &&
                  ((state == REL_DB && db_next == DB_LAST) || (DB_ONE && state == HELD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            cand    <= '0;
            db      <= 4'd0;
        end else if (tick) begin
            unique case (state)
                SCAN: begin
                    if (row_idle) begin
                        col_idx <= col_idx + 2'd1;
                    end else begin
                        cand  <= {col_idx, keyrow};
                        db    <= 4'd1;
                        state <= DB_ONE ? HELD : PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (keyrow != cand[3:0]) begin
                        state <= SCAN;
                    end else begin
                        db <= db_next;
                        if (db_next == DB_LAST) state <= HELD;
                    end
                end
                HELD: begin
                    if (row_idle) begin
                        db <= 4'd1;
                        if (DB_ONE) begin
                            col_idx <= col_idx + 2'd1;
                            state   <= SCAN;
                        end else begin
                            state <= REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (!row_idle) begin
                        state <= HELD;
                    end else begin
                        db <= db_next;
                        if (db_next == DB_LAST) begin
                            col_idx <= col_idx + 2'd1;
                            state   <= SCAN;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign keycolumn = col_strobe(col_idx);
    assign pop       = key_valid && key_ready;
    assign key_valid = !empty;

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)                      overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
        else if (clr_ovf)             overflow <= 1'b0;
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cand),
        .rdata (key_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: an emulated 4x4 key matrix, keystroke-level
// expected codes in a scoreboard queue, and a monitor that pops on handshakes.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DB_TICKS = 3;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keyrow;
    logic [3:0] keycolumn;
    logic [5:0] key_data;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DB_TICKS),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyrow     (keyrow),
        .keycolumn  (keycolumn),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    // Physical key matrix: pressed[c][r] set means switch (c,r) closed.
    logic [3:0] pressed [4];
    always_comb begin
        keyrow = 4'b1111;
        for (int c = 0; c < 4; c++)
            if (!keycolumn[3-c]) keyrow = keyrow & ~pressed[c];
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] exp_q [$];
    bit         stall   = 1'b1;
    bit         mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: drives random ready, checks stall stability and popped codes.
    logic [5:0] last_data  = '0;
    bit         last_stall = 1'b0;
    always @(negedge clk) begin
        logic       rdy;
        logic [5:0] exp;
        rdy = !stall && ($urandom_range(0, 3) != 0);
        if (mon_en && key_valid && last_stall)
            check("hold_stable", {26'd0, key_data}, {26'd0, last_data});
        key_ready = rdy;
        if (mon_en && key_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {26'd0, key_data}, 32'hFFFF);
            end else begin
                exp = exp_q.pop_front();
                check("pop_code", {26'd0, key_data}, {26'd0, exp});
            end
        end
        last_stall = key_valid && !rdy;
        last_data  = key_data;
    end

    task automatic wait_ticks(input int n);
        repeat (n * SCAN_DIV) @(negedge clk);
    endtask

    function automatic logic [5:0] code_of(input int c, input logic [3:0] mask);
        logic [1:0] ci;
        ci = 2'(c);
        return {ci, ~mask};
    endfunction

    // One keystroke; the scanner must find it within the hold window.
    task automatic keystroke(input int c, input logic [3:0] mask, input int hold,
                             input bit bounce, input bit expect_push);
        pressed[c] = mask;
        wait_ticks(hold);
        pressed[c] = 4'b0000;
        if (bounce) begin
            wait_ticks(1);
            pressed[c] = mask;
            wait_ticks(1);
            pressed[c] = 4'b0000;
        end
        if (expect_push) exp_q.push_back(code_of(c, mask));
        wait_ticks(5);
    endtask

    task automatic glitch(input int c, input logic [3:0] mask);
        pressed[c] = mask;
        wait_ticks($urandom_range(1, 2));
        pressed[c] = 4'b0000;
        wait_ticks(3);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || key_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, {31'd0, cyc < 3000}, 32'd1);
    endtask

    function automatic logic [3:0] rand_mask();
        int r1, r2;
        r1 = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) begin
            r2 = (r1 + $urandom_range(1, 3)) % 4;
            return 4'((1 << r1) | (1 << r2));
        end
        return 4'(1 << r1);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int c = 0; c < 4; c++) pressed[c] = 4'b0000;

        // Reset values and idle scan.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_keycolumn", {28'd0, keycolumn}, 32'b0111);
        check("rst_key_data",  {26'd0, key_data}, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_overflow",  {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 20 * SCAN_DIV; k++) begin
            @(negedge clk);
            check("idle_keycolumn", {28'd0, keycolumn}, {28'd0, 4'b1000 >> ((k / SCAN_DIV) % 4)} ^ 32'hF);
        end
        check("idle_no_valid", {31'd0, key_valid}, 32'd0);
        mon_en = 1'b1;

        // Single keystroke with latency from release to key_valid.
        pressed[2] = 4'b0100;
        wait_ticks(8);
        pressed[2] = 4'b0000;
        exp_q.push_back(6'b10_1011);
        cnt = 0;
        while (!key_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("push_latency_ok", {31'd0, cnt >= 9 && cnt <= 12}, 32'd1);
        check("first_code", {26'd0, key_data}, 32'b10_1011);
        wait_ticks(3);
        check("single_push_count", {29'd0, fifo_count}, 32'd1);
        stall = 1'b0;
        wait_drain("drain_first");

        // Randomised keystrokes, glitches and release bounce.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(0, 3), rand_mask());
            keystroke($urandom_range(0, 3), rand_mask(), $urandom_range(8, 12),
                      bit'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain("drain_random");

        // Overflow: five keystrokes into a stalled four-entry FIFO.
        stall = 1'b1;
        @(negedge clk);
        begin
            logic [5:0] first_code;
            logic [3:0] m;
            first_code = '0;
            for (int i = 0; i < 5; i++) begin
                int c;
                c = $urandom_range(0, 3);
                m = rand_mask();
                if (i == 0) first_code = code_of(c, m);
                keystroke(c, m, 9, 1'b0, i < 4);
            end
            check("ovf_count", {29'd0, fifo_count}, 32'd4);
            check("ovf_flag", {31'd0, overflow}, 32'd1);
            check("ovf_head", {26'd0, key_data}, {26'd0, first_code});
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        stall = 1'b0;
        wait_drain("drain_ovf");
        check("drained_valid", {31'd0, key_valid}, 32'd0);

        // Reset while a key is held, with a code already queued.
        stall = 1'b1;
        keystroke(1, 4'b0010, 9, 1'b0, 1'b1);
        pressed[3] = 4'b1000;
        wait_ticks(8);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("mid_rst_keycolumn", {28'd0, keycolumn}, 32'b0111);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_data", {26'd0, key_data}, 32'd0);
        rst = 1'b0;
        wait_ticks(8);
        pressed[3] = 4'b0000;
        exp_q.push_back(6'b11_0111);
        wait_ticks(5);
        check("post_rst_count", {29'd0, fifo_count}, 32'd1);
        stall = 1'b0;
        wait_drain("drain_post_rst");
        check("final_overflow", {31'd0, overflow}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
